// File: rtl/uart_rx_fifo_periph.sv
// UART 8N1 receiver with 16x oversampling, a small byte FIFO and a
// three-register bus window (RXDATA / STATUS / CTRL) with a level interrupt.
module uart_rx_fifo_periph #(
    parameter int          OVS_DIV    = 326,
    parameter int          DEPTH_LOG2 = 3,
    parameter logic [31:0] BASE       = 32'h40000030
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irqout,
    input  logic        UART_rxd
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int PW    = $clog2(OVS_DIV);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e                state_q;
    logic                  sync1_q, sync2_q, prev_q;
    logic [PW-1:0]         pre_q;
    logic [3:0]            tcnt_q;
    logic [2:0]            bit_q;
    logic [7:0]            shift_q;
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wp_q, rp_q;
    logic [CW-1:0]         count_q;
    logic                  ovr_q, ferr_q, irq_en_q, irq_q;

    logic        tick, start_det, stop_smp, push, push_ok, pop, ferr_set, ovr_set;
    logic        not_empty, full, in_win;
    logic [29:0] off;
    logic [31:0] status;
    logic        unused_bits;

    assign unused_bits = ^{addr[1:0], wdata[31:4], wdata[1]};

    // Bus decode: word offset into the window, only the word address matters.
    assign off       = addr[31:2] - BASE[31:2];
    assign in_win    = (off < 30'd3);
    assign not_empty = (count_q != '0);
    assign full      = (count_q == CW'(DEPTH));
    assign pop       = rd && in_win && (off == 30'd0) && not_empty;

    // Receiver event decode: a tick per OVS_DIV clocks, edge only seen when idle.
    assign tick      = (pre_q == PW'(OVS_DIV - 1));
    assign start_det = (state_q == S_IDLE) && prev_q && !sync2_q;
    assign stop_smp  = (state_q == S_STOP) && tick && (tcnt_q == 4'd15);
    assign push      = stop_smp && sync2_q;
    assign ferr_set  = stop_smp && !sync2_q;
    // A pop in the same cycle frees a slot, so a push to a full FIFO survives.
    assign push_ok   = push && (!full || pop);
    assign ovr_set   = push && full && !pop;

    // Two-flop synchroniser plus previous-value flop for falling-edge detect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= UART_rxd;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Oversample prescaler, realigned to the detected start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 pre_q <= '0;
        else if (start_det || tick) pre_q <= '0;
        else                        pre_q <= pre_q + PW'(1);
    end

    // Receiver FSM: mid-bit sampling at 8 ticks into start, then every 16.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            tcnt_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_det) begin
                        state_q <= S_START;
                        tcnt_q  <= '0;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (tcnt_q == 4'd7) begin
                            tcnt_q  <= '0;
                            bit_q   <= '0;
                            state_q <= sync2_q ? S_IDLE : S_DATA;
                        end else begin
                            tcnt_q <= tcnt_q + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (tcnt_q == 4'd15) begin
                            tcnt_q  <= '0;
                            shift_q <= {sync2_q, shift_q[7:1]};
                            bit_q   <= bit_q + 3'd1;
                            if (bit_q == 3'd7) state_q <= S_STOP;
                        end else begin
                            tcnt_q <= tcnt_q + 4'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (tcnt_q == 4'd15) begin
                            tcnt_q  <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            tcnt_q <= tcnt_q + 4'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wp_q] <= shift_q;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wp_q <= wp_q + 1'b1;
            if (pop)     rp_q <= rp_q + 1'b1;
            if (push_ok && !pop)      count_q <= count_q + CW'(1);
            else if (!push_ok && pop) count_q <= count_q - CW'(1);
        end
    end

    // Sticky flags (set beats a same-cycle clear), irq enable, registered irq.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr && in_win && off == 30'd1) begin
                if (wdata[2]) ovr_q  <= 1'b0;
                if (wdata[3]) ferr_q <= 1'b0;
            end
            if (ovr_set)  ovr_q  <= 1'b1;
            if (ferr_set) ferr_q <= 1'b1;
            if (wr && in_win && off == 30'd2) irq_en_q <= wdata[0];
            irq_q <= irq_en_q && (not_empty || ovr_q);
        end
    end

    assign irqout = irq_q;

    // STATUS word assembly.
    always_comb begin
        status         = '0;
        status[0]      = not_empty;
        status[1]      = full;
        status[2]      = ovr_q;
        status[3]      = ferr_q;
        status[4 +: CW] = count_q;
    end

    // Read mux; RXDATA shows the head before the pop lands.
    always_comb begin
        rdata = '0;
        if (rd && in_win) begin
            case (off[1:0])
                2'd0:    rdata = not_empty ? {24'b0, mem_q[rp_q]} : 32'b0;
                2'd1:    rdata = status;
                2'd2:    rdata = {31'b0, irq_en_q};
                default: rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo_periph.sv
// Bench for uart_rx_fifo_periph: queue-based model checked every cycle,
// plus directed literal checks on the key points of each scenario.
module tb_uart_rx_fifo_periph;
    localparam int          OVS  = 4;
    localparam logic [31:0] BASE = 32'h40000030;
    localparam logic [29:0] BASE_W = 30'(BASE >> 2);
    localparam int          BITC = 16 * OVS;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rd = 1'b1;
    logic        wr = 1'b0;
    logic [31:0] addr = BASE + 32'd4;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irqout;
    logic        rxd = 1'b1;

    uart_rx_fifo_periph #(.OVS_DIV(OVS), .DEPTH_LOG2(3), .BASE(BASE)) dut (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr),
        .wdata(wdata), .rdata(rdata), .irqout(irqout), .UART_rxd(rxd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int c; logic [7:0] b; bit ok; } ev_t;
    ev_t          evq[$];
    logic [7:0]   mq[$];
    bit           m_ovr = 0, m_ferr = 0, m_ien = 0, m_irq = 0;

    function automatic int win_off(input logic [31:0] a);
        logic [29:0] d;
        d = a[31:2] - BASE_W;
        return (d < 30'd3) ? int'(d) : -1;
    endfunction

    function automatic logic [31:0] exp_rdata();
        int o;
        int n;
        if (!rd) return 32'h0;
        o = win_off(addr);
        n = mq.size();
        case (o)
            0:       return (n > 0) ? {24'h0, mq[0]} : 32'h0;
            1:       return (n * 16) + (m_ferr ? 8 : 0) + (m_ovr ? 4 : 0) + ((n == 8) ? 2 : 0) + ((n > 0) ? 1 : 0);
            2:       return {31'h0, m_ien};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete(); evq.delete();
            m_ovr = 0; m_ferr = 0; m_ien = 0; m_irq = 0;
        end else begin
            bit nirq;
            int o;
            nirq = m_ien && (mq.size() > 0 || m_ovr);
            o = win_off(addr);
            if (rd && o == 0 && mq.size() > 0) void'(mq.pop_front());
            if (wr && o == 1) begin
                if (wdata[2]) m_ovr = 0;
                if (wdata[3]) m_ferr = 0;
            end
            if (wr && o == 2) m_ien = wdata[0];
            if (evq.size() > 0 && evq[0].c == cyc) begin
                if (!evq[0].ok)         m_ferr = 1;
                else if (mq.size() < 8) mq.push_back(evq[0].b);
                else                    m_ovr = 1;
                void'(evq.pop_front());
            end
            m_irq = nirq;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        chk("model_rdata", rdata, exp_rdata());
        chk("model_irqout", {31'h0, irqout}, {31'h0, m_irq});
    end

    // ---------------- stimulus helpers ----------------
    int stop_cyc = 0;

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stopb);
        ev_t e;
        @(posedge clk); #1;
        rxd = 1'b0;
        stop_cyc = cyc + 2 + 152 * OVS;
        e.c = stop_cyc; e.b = b; e.ok = stopb;
        evq.push_back(e);
        for (int i = 0; i < 8; i++) begin
            hold(BITC);
            rxd = b[i];
        end
        hold(BITC);
        rxd = stopb;
        hold(BITC);
        rxd = 1'b1;
    endtask

    task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        addr = a; rd = 1'b1;
        @(negedge clk);
        d = rdata;
        @(posedge clk); #1;
        addr = BASE + 32'd4;
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] v);
        @(posedge clk); #1;
        addr = a; wdata = v; wr = 1'b1;
        @(posedge clk); #1;
        wr = 1'b0; wdata = '0; addr = BASE + 32'd4;
    endtask

    task automatic at_cycle(input int target);
        for (int i = 0; i < 5000 && cyc != target; i++) begin
            @(posedge clk); #1;
        end
        if (cyc != target) begin
            total++;
            $display("FAIL wait_cycle: got cycle %0d, expected %0d", cyc, target);
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [31:0] d;
        int s;
        hold(3);
        reset = 1'b1;
        hold(3);

        // Reset state
        rd_reg(BASE + 32'd4, d);  chk("rst_status", d, 32'h0);
        rd_reg(BASE + 32'd8, d);  chk("rst_ctrl", d, 32'h0);
        rd_reg(BASE, d);          chk("rst_rxdata", d, 32'h0);
        rd_reg(BASE + 32'd12, d); chk("out_of_window", d, 32'h0);
        chk("rst_irq", {31'h0, irqout}, 32'h0);

        // Single byte 0xA5 with interrupt enabled
        wr_reg(BASE + 32'd8, 32'h1);
        rd_reg(BASE + 32'd8, d);  chk("ctrl_rb", d, 32'h1);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                @(posedge clk); #2;
                s = stop_cyc;
                at_cycle(s + 1); #3;
                chk("a5_status", rdata, 32'h11);
                chk("a5_irq_lag", {31'h0, irqout}, 32'h0);
                at_cycle(s + 2); #3;
                chk("a5_irq", {31'h0, irqout}, 32'h1);
            end
        join
        rd_reg(BASE, d);          chk("a5_data", d, 32'hA5);
        rd_reg(BASE + 32'd4, d);  chk("a5_status_after", d, 32'h0);
        hold(2);
        chk("a5_irq_after", {31'h0, irqout}, 32'h0);

        // Nine bytes, overrun on the ninth
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
        rd_reg(BASE + 32'd4, d);  chk("ovr_status", d, 32'h87);
        for (int i = 1; i <= 8; i++) begin
            rd_reg(BASE, d);      chk("ovr_drain", d, 32'(i));
        end
        wr_reg(BASE + 32'd4, 32'h4);
        rd_reg(BASE + 32'd4, d);  chk("ovr_clear", d, 32'h0);

        // Glitch rejection, then a framing error
        @(posedge clk); #1;
        rxd = 1'b0;
        hold(3 * OVS);
        rxd = 1'b1;
        hold(200);
        rd_reg(BASE + 32'd4, d);  chk("glitch_status", d, 32'h0);
        send_frame(8'h55, 1'b0);
        rd_reg(BASE + 32'd4, d);  chk("ferr_status", d, 32'h08);
        wr_reg(BASE + 32'd4, 32'h8);
        rd_reg(BASE + 32'd4, d);  chk("ferr_clear", d, 32'h0);

        // Pop coincident with push while full
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1);
        rd_reg(BASE + 32'd4, d);  chk("full_status", d, 32'h83);
        fork
            send_frame(8'h18, 1'b1);
            begin
                @(posedge clk); #2;
                s = stop_cyc;
                at_cycle(s);
                addr = BASE;
                @(negedge clk);
                chk("coinc_head", rdata, 32'h10);
                @(posedge clk); #1;
                addr = BASE + 32'd4;
            end
        join
        rd_reg(BASE + 32'd4, d);  chk("coinc_status", d, 32'h83);
        for (int i = 1; i <= 8; i++) begin
            rd_reg(BASE, d);      chk("coinc_order", d, 32'h10 + 32'(i));
        end

        // Reset mid-frame
        send_frame(8'h77, 1'b1);
        rd_reg(BASE + 32'd4, d);  chk("pre_rst_status", d, 32'h11);
        @(posedge clk); #1;
        rxd = 1'b0;
        hold(4 * BITC);
        reset = 1'b0;
        rxd = 1'b1;
        hold(3);
        reset = 1'b1;
        hold(40);
        rd_reg(BASE + 32'd4, d);  chk("midrst_status", d, 32'h0);
        rd_reg(BASE + 32'd8, d);  chk("midrst_ctrl", d, 32'h0);
        send_frame(8'h3C, 1'b1);
        rd_reg(BASE, d);          chk("post_rst_data", d, 32'h3C);
        rd_reg(BASE + 32'd4, d);  chk("post_rst_status", d, 32'h0);

        hold(5);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo_periph.md
# uart_rx_fifo_periph

Memory-mapped UART receiver peripheral: a bus responder that serves the pipelined processor's MEM-stage load/store port (`rd`/`wr`/`addr`/`wdata`/`rdata`) and raises its interrupt input. It deserialises 8N1 frames from an external transmitter using 16x oversampling and buffers received bytes in a small FIFO. Software drains the FIFO by polling or on interrupt. It sits in the peripheral address space (`addr[30]=1`), beside the existing LED, switch, digit-tube and timer registers.

## Interface
Parameters:
- `OVS_DIV`, 326: clocks per oversample tick (50 MHz / (9600×16)); legal range ≥ 2.
- `DEPTH_LOG2`, 3: FIFO depth = 2^DEPTH_LOG2 = 8 entries.
- `BASE`, 32'h40000030: word-aligned base address of the 3-register window.

Ports:
- `clk` input 1: system clock, all state on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `rd` input 1: read strobe from the processor MEM stage.
- `wr` input 1: write strobe from the processor MEM stage.
- `addr` input 32: byte address; decode compares `addr[31:2]` only.
- `wdata` input 32: write data.
- `rdata` output 32: read data. Combinational from `rd`/`addr`/state; 0 when not selected.
- `irqout` output 1: level interrupt request.
- `UART_rxd` input 1: asynchronous serial input, idle high.

## Operation
- Register map:
  - `BASE+0` RXDATA, read-only: `{24'b0, head byte}`. A read pops one entry. Reading when empty returns 0 and does not pop.
  - `BASE+4` STATUS:
    - `[0]` not_empty
    - `[1]` full
    - `[2]` overrun (sticky)
    - `[3]` frame_err (sticky)
    - `[7:4]` count (0..8)
    - other bits 0
  - Write to STATUS: each 1 in `wdata[3:2]` clears the matching sticky bit.
  - `BASE+8` CTRL, read/write: `[0]` irq_en. Other bits read 0.
- Accesses outside the window: no effect, `rdata` = 0.
- `rd` and `wr` asserted together: both take effect.
- Input sync: two flip-flops, both reset to 1. All receiver logic uses only the synchronised bit.
- Receiver FSM states: IDLE, START, DATA, STOP.
  - IDLE: a falling edge on the synced line (prev=1, now=0) → START. The tick prescaler and tick counter are cleared in that same cycle.
  - START: after 8 ticks, sample the line.
    - 0 → DATA, bit index = 0.
    - 1 → IDLE (glitch rejected, nothing recorded).
  - DATA: every 16 ticks, sample into shift register, LSB first. After bit 7 → STOP.
  - STOP: after 16 ticks, sample the line.
    - 1 → push byte, then IDLE.
    - 0 → set frame_err, discard byte, IDLE.
  - A new start bit is only recognised via a fresh 1→0 edge.
- FIFO: circular, read/write pointers of DEPTH_LOG2 bits that wrap modulo depth; count is DEPTH_LOG2+1 bits.
  - Push when full: byte dropped, overrun set, FIFO unchanged. Exception: a pop in the same cycle frees a slot, so the push is accepted.
  - Push and pop in the same cycle (non-empty): both performed, count unchanged.
  - Pop when empty: ignored.
- `irqout` = irq_en & (not_empty | overrun).

## Timing
- Reset values:
  - `rdata` = 0 (no access), `irqout` = 0.
  - FIFO empty, pointers 0, sticky bits 0, irq_en 0.
  - FSM in IDLE, sync flops 1.
- Reset asserted mid-frame: the frame is abandoned and the FIFO is emptied. After release, the line must show 1→0 before any reception.
- Edge detection occurs 2 clocks after the pin falls (synchroniser).
- Sample points, relative to the detection cycle D:
  - start bit at D + 8·OVS_DIV
  - data bit k at D + (24+16k)·OVS_DIV
  - stop bit at D + 152·OVS_DIV
- The push is visible in STATUS in the cycle after the stop sample.
- `irqout` rises 1 clock after the push (registered state).
- RXDATA pop takes effect at the clock edge ending the `rd` cycle. `rdata` in that cycle shows the pre-pop head. STATUS.count updates the next cycle.
- CTRL and sticky-bit writes take effect at the clock edge ending the `wr` cycle.
- Back-to-back frames with a single stop bit are received without loss. IDLE is re-entered before the next start edge can arrive.

## Test plan
- Reset, then read STATUS/CTRL/RXDATA → 0, 0, 0; `irqout`=0; a read at BASE+12 → 0.
- OVS_DIV=4, send 0xA5 (8N1, 64 clk/bit), irq_en=1:
  - STATUS = 0x11 one clock after the stop sample; `irqout`=1 one clock later.
  - Read RXDATA → 0xA5; STATUS → 0x00; `irqout`=0.
- Send 9 bytes 0x01..0x09 without reading:
  - STATUS = 0x87 (count 8, full, overrun, not_empty).
  - 8 reads return 0x01..0x08.
  - Write STATUS with `wdata`=4 → overrun cleared.
- Glitch: drive rxd low for 3·OVS_DIV clocks, then high → no push, STATUS unchanged. Then send a frame whose stop bit = 0 → frame_err set, count 0.
- Pop coincident with push while full:
  - The ninth byte's push cycle aligned to an RXDATA read → no overrun, count stays 8.
  - Ordering check: pointers wrap and the bytes read out in the correct sequence.
- Assert reset mid-DATA: after release, STATUS=0. Then a clean 0x3C frame is received correctly.
